// File: rtl/lcd_fetch_if.sv
// CPU register bus, VRAM read port and pixel/sync outputs of the LCD scan-out engine.
interface lcd_fetch_if;
  logic [5:0]  AB;
  logic        cpu_rnw;
  logic        lcd_cs;
  logic [7:0]  data_in;
  logic [7:0]  vram_data;
  logic [12:0] vram_addr;
  logic        lcd_en;
  logic [1:0]  pixel;
  logic        pix_valid;
  logic        hsync;
  logic        vsync;

  modport master (
    output AB, cpu_rnw, lcd_cs, data_in, vram_data,
    input  vram_addr, lcd_en, pixel, pix_valid, hsync, vsync
  );

  modport slave (
    input  AB, cpu_rnw, lcd_cs, data_in, vram_data,
    output vram_addr, lcd_en, pixel, pix_valid, hsync, vsync
  );
endinterface

// File: rtl/lcd_fetch.sv
// VRAM scan-out: one stolen VRAM slot per 6 ce ticks, 2bpp unpack, line/frame sync.
// Define LCD_FINE_SCROLL_EN to fetch 41 bytes per line and honour xscroll[1:0].
module lcd_fetch (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  lcd_fetch_if.slave bus
);
`ifdef LCD_FINE_SCROLL_EN
  localparam logic [5:0] LAST_SLOT = 6'd40;
`else
  localparam logic [5:0] LAST_SLOT = 6'd39;
`endif

  logic [2:0]  div;
  logic [5:0]  slot;
  logic [7:0]  line;
  logic [12:0] line_base;
  logic [7:0]  xscroll, sh_xscroll, sh_yscroll;
  logic        disp_en, sh_disp_en;
  logic [7:2]  shreg;
  logic        grp_pend, data_pend;
  logic        vs_tick, active_slot, fetch, cpu_wr, pix_ok;
  logic [12:0] addr_calc, lb_load;
  logic [1:0]  pix_src;

  assign vs_tick     = (div == 3'd0) && (slot == 6'd0) && (line == 8'd0);
  assign active_slot = (line < 8'd160) && (slot <= LAST_SLOT);
  assign fetch       = active_slot && disp_en;
  assign cpu_wr      = ~bus.cpu_rnw & bus.lcd_cs;
  assign addr_calc   = line_base + {7'd0, xscroll[7:2]} + {7'd0, slot};
  assign lb_load     = {5'd0, sh_yscroll} * 13'd48;
  assign bus.lcd_en  = (div == 3'd5) && fetch;

`ifdef LCD_FINE_SCROLL_EN
  logic [5:0] grp_slot;
  logic [7:0] pidx;
  // Pixel index within the line decides the xscroll[1:0] leading-edge blanking.
  assign pidx   = {grp_slot, 2'b00} + {6'd0, div[1:0]};
  assign pix_ok = (pidx >= {6'd0, xscroll[1:0]}) && (pidx < {6'd0, xscroll[1:0]} + 8'd160);
`else
  logic unused_fine;
  assign unused_fine = &{1'b0, xscroll[1:0]};
  assign pix_ok      = 1'b1;
`endif

  // First pixel comes straight off the VRAM bus; the rest from the shift register.
  always_comb begin
    pix_src = 2'b00;
    case (div[1:0])
      2'd0:    pix_src = data_pend ? bus.vram_data[1:0] : 2'b00;
      2'd1:    pix_src = shreg[3:2];
      2'd2:    pix_src = shreg[5:4];
      default: pix_src = shreg[7:6];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div           <= 3'd0;
      slot          <= 6'd0;
      line          <= 8'd0;
      line_base     <= 13'd0;
      xscroll       <= 8'd0;
      disp_en       <= 1'b0;
      sh_xscroll    <= 8'd0;
      sh_yscroll    <= 8'd0;
      sh_disp_en    <= 1'b0;
      shreg         <= 6'd0;
      grp_pend      <= 1'b0;
      data_pend     <= 1'b0;
`ifdef LCD_FINE_SCROLL_EN
      grp_slot      <= 6'd0;
`endif
      bus.vram_addr <= 13'd0;
      bus.pixel     <= 2'b00;
      bus.pix_valid <= 1'b0;
      bus.hsync     <= 1'b0;
      bus.vsync     <= 1'b0;
    end else if (ce) begin
      if (div == 3'd5) begin
        div       <= 3'd0;
        grp_pend  <= active_slot;
        data_pend <= fetch;
`ifdef LCD_FINE_SCROLL_EN
        grp_slot  <= slot;
`endif
        if (slot == 6'd47) begin
          slot      <= 6'd0;
          line      <= (line == 8'd163) ? 8'd0 : line + 8'd1;
          line_base <= line_base + 13'd48;
        end else begin
          slot <= slot + 6'd1;
        end
      end else begin
        div <= div + 3'd1;
      end

      if (cpu_wr) begin
        case (bus.AB)
          6'h02:   sh_xscroll <= bus.data_in;
          6'h03:   sh_yscroll <= bus.data_in;
          6'h26:   sh_disp_en <= bus.data_in[3];
          default: ;
        endcase
      end

      // Live copies read the old shadow, so a same-tick write waits a frame.
      if (vs_tick) begin
        xscroll   <= sh_xscroll;
        disp_en   <= sh_disp_en;
        line_base <= lb_load;
      end

      bus.vram_addr <= addr_calc;
      bus.hsync     <= (div == 3'd0) && (slot == 6'd0);
      bus.vsync     <= vs_tick;

      if (grp_pend && !div[2]) begin
        bus.pix_valid <= pix_ok;
        bus.pixel     <= pix_ok ? pix_src : 2'b00;
        if (div == 3'd0) shreg <= data_pend ? bus.vram_data[7:2] : 6'd0;
      end else begin
        bus.pix_valid <= 1'b0;
        bus.pixel     <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_lcd_fetch.sv
// Bench for lcd_fetch: time-indexed raster model plus random CPU bus noise and VRAM contents.
module tb_lcd_fetch;
  localparam int FR = 47232;
`ifdef LCD_FINE_SCROLL_EN
  localparam int NS   = 41;
  localparam bit FINE = 1'b1;
`else
  localparam int NS   = 40;
  localparam bit FINE = 1'b0;
`endif

  logic clk, reset_n, ce;
  lcd_fetch_if bus();
  lcd_fetch dut (.clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:8191];
  logic [7:0]  sh_x, sh_y, live_x, live_y, xs;
  logic        sh_en, live_en;
  logic [12:0] first_addr;
  bit          seen_en;
  int t;
  int errors = 0;
  int checks = 0;
  int n_en, n_pv, n_hs, n_vs;

  function automatic logic [12:0] addr_of(input int l, input int s);
    int a;
    a = int'(live_y) * 48 + 48 * l + int'(live_x >> 2) + s;
    return 13'(a % 8192);
  endfunction

  // Expected outputs seen just before ce tick t: lcd_en/vram_addr for tick t,
  // registered pixel/sync outputs produced by tick t-1.
  function automatic logic [18:0] model_out(input int tt);
    int w, l, s, d, p, fs;
    logic en, vl, hs, vs;
    logic [12:0] a;
    logic [1:0] px;
    logic [7:0] b;
    w  = tt % FR; l = w / 288; s = (w % 288) / 6; d = w % 6;
    en = live_en && (l < 160) && (s < NS) && (d == 5);
    a  = en ? addr_of(l, s) : 13'd0;
    px = 2'b00; vl = 1'b0; hs = 1'b0; vs = 1'b0;
    if (tt > 0) begin
      w  = (tt - 1) % FR; l = w / 288; s = (w % 288) / 6; d = w % 6;
      hs = (w % 288) == 0;
      vs = (w == 0);
      fs = FINE ? int'(live_x[1:0]) : 0;
      if ((l < 160) && (d <= 3) && (s >= 1) && (s - 1 < NS)) begin
        p  = 4 * (s - 1) + d;
        vl = (p >= fs) && (p < fs + 160);
        if (vl && live_en) begin
          b  = mem[addr_of(l, s - 1)];
          px = b[2*d +: 2];
        end
      end
    end
    return {en, a, px, vl, hs, vs};
  endfunction

  task automatic clear_counts();
    n_en = 0; n_pv = 0; n_hs = 0; n_vs = 0; seen_en = 0;
  endtask

  task automatic model_reset();
    t = 0; sh_x = 0; sh_y = 0; sh_en = 0; live_x = 0; live_y = 0; live_en = 0;
  endtask

  task automatic tick(input bit wr, input logic [5:0] ab, input logic [7:0] dat, input string tag);
    logic [18:0] want, got;
    ce = 1'b1;
    if (wr) begin
      bus.cpu_rnw = 1'b0; bus.lcd_cs = 1'b1; bus.AB = ab; bus.data_in = dat;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin bus.cpu_rnw = 1'b1; bus.lcd_cs = 1'b0; end
        1:       begin bus.cpu_rnw = 1'b1; bus.lcd_cs = 1'b1; end
        default: begin bus.cpu_rnw = 1'b0; bus.lcd_cs = 1'b0; end
      endcase
      bus.AB = 6'($urandom); bus.data_in = 8'($urandom);
    end
    @(negedge clk);
    want = model_out(t);
    got  = {bus.lcd_en, want[18] ? bus.vram_addr : 13'd0, bus.pixel, bus.pix_valid, bus.hsync, bus.vsync};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d got{en,addr,pix,vld,hs,vs}=%05h want=%05h", tag, t, got, want);
    end
    if (bus.lcd_en)    n_en++;
    if (bus.pix_valid) n_pv++;
    if (bus.hsync)     n_hs++;
    if (bus.vsync)     n_vs++;
    if (bus.lcd_en && !seen_en) begin seen_en = 1; first_addr = bus.vram_addr; end
    @(posedge clk);
    if (t % FR == 0) begin live_x = sh_x; live_y = sh_y; live_en = sh_en; end
    if (wr) begin
      case (ab)
        6'h02:   sh_x  = dat;
        6'h03:   sh_y  = dat;
        6'h26:   sh_en = dat[3];
        default: ;
      endcase
    end
    #1;
    bus.vram_data = want[18] ? mem[want[17:5]] : 8'($urandom);
    bus.cpu_rnw = 1'b1; bus.lcd_cs = 1'b0;
    t++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce = 1'b0;
    bus.cpu_rnw = 1'b0; bus.lcd_cs = 1'b1; bus.AB = 6'h26; bus.data_in = 8'hFF;
    repeat (2) @(posedge clk);
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (bus.vram_addr !== 13'd0) begin errors++; $display("FAIL reset_vram_addr got=%0d want=0", bus.vram_addr); end
    checks++; if (bus.lcd_en !== 1'b0)     begin errors++; $display("FAIL reset_lcd_en got=%b want=0", bus.lcd_en); end
    checks++; if (bus.pixel !== 2'b00)     begin errors++; $display("FAIL reset_pixel got=%0d want=0", bus.pixel); end
    checks++; if (bus.pix_valid !== 1'b0)  begin errors++; $display("FAIL reset_pix_valid got=%b want=0", bus.pix_valid); end
    checks++; if (bus.hsync !== 1'b0)      begin errors++; $display("FAIL reset_hsync got=%b want=0", bus.hsync); end
    checks++; if (bus.vsync !== 1'b0)      begin errors++; $display("FAIL reset_vsync got=%b want=0", bus.vsync); end
    @(posedge clk); #1;
    reset_n = 1'b1; bus.lcd_cs = 1'b0; bus.cpu_rnw = 1'b1;
    model_reset();
  endtask

  // Frame 1 always runs disabled; its writes only arm the next frame.
  task automatic test_disabled_frame();
    clear_counts();
    for (int i = 0; i < FR; i++) begin
      if (i == 100)        tick(1'b1, 6'h26, 8'h08 | 8'($urandom), "frame1_wr_en");
      else if (i == 5000)  tick(1'b1, 6'h03, 8'd3, "frame1_wr_y");
      else if (i == 20000) tick(1'b1, 6'h03, 8'd170, "frame1_wr_y2");
      else if (i == 30000) tick(1'b1, 6'h02, xs, "frame1_wr_x");
      else                 tick(1'b0, 6'h00, 8'h00, "frame1");
    end
    checks++; if (n_en != 0)     begin errors++; $display("FAIL disabled_lcd_en_count got=%0d want=0", n_en); end
    checks++; if (n_pv != 25600) begin errors++; $display("FAIL disabled_pix_valid_count got=%0d want=25600", n_pv); end
    checks++; if (n_hs != 164)   begin errors++; $display("FAIL frame_hsync_count got=%0d want=164", n_hs); end
    checks++; if (n_vs != 1)     begin errors++; $display("FAIL frame_vsync_count got=%0d want=1", n_vs); end
  endtask

  // yscroll=170 puts line 0 at 8160 so it wraps through address 0; line 1 lands at 16.
  task automatic test_scan_frame();
    int exp_first;
    clear_counts();
    tick(1'b1, 6'h03, 8'd7, "vsync_tick_wr");
    for (int i = 1; i < 10 * 288; i++) begin
      if (i == 4 * 288 + 10)      tick(1'b1, 6'h26, 8'h00, "midframe_wr_en");
      else if (i == 5 * 288 + 20) tick(1'b1, 6'h02, 8'($urandom), "midframe_wr_x");
      else if (i == 6 * 288)      tick(1'b1, 6'h03, 8'($urandom), "midframe_wr_y");
      else                        tick(1'b0, 6'h00, 8'h00, "scan");
    end
    exp_first = (170 * 48 + int'(xs >> 2)) % 8192;
    checks++; if (!seen_en || first_addr !== 13'(exp_first)) begin
      errors++; $display("FAIL first_fetch_addr got=%0d want=%0d", first_addr, exp_first); end
    checks++; if (n_en != 10 * NS) begin errors++; $display("FAIL scan_lcd_en_count got=%0d want=%0d", n_en, 10 * NS); end
    checks++; if (n_pv != 1600)    begin errors++; $display("FAIL scan_pix_valid_count got=%0d want=1600", n_pv); end
    checks++; if (n_hs != 10)      begin errors++; $display("FAIL scan_hsync_count got=%0d want=10", n_hs); end
  endtask

  task automatic test_ce_freeze();
    logic [18:0] want, got;
    for (int i = 0; i < 6; i++) if ((t % 6) != 5) tick(1'b0, 6'h00, 8'h00, "pre_freeze");
    ce = 1'b0;
    want = model_out(t);
    repeat (12) begin
      @(negedge clk);
      got = {bus.lcd_en, want[18] ? bus.vram_addr : 13'd0, bus.pixel, bus.pix_valid, bus.hsync, bus.vsync};
      checks++;
      if (got !== want) begin errors++; $display("FAIL ce_freeze got=%05h want=%05h", got, want); end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) tick(1'b0, 6'h00, 8'h00, "post_freeze");
  endtask

  task automatic test_reset_midline();
    logic [18:0] got;
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if ((t % 6) == 2 && ((t % 288) / 6) >= 2 && ((t % 288) / 6) <= 39 && ((t % FR) / 288) < 160) found = 1;
      else tick(1'b0, 6'h00, 8'h00, "seek_midline");
    end
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    got = {bus.lcd_en, bus.vram_addr, bus.pixel, bus.pix_valid, bus.hsync, bus.vsync};
    checks++;
    if (!found || got !== 19'd0) begin errors++; $display("FAIL midline_reset_outputs got=%05h want=00000 found=%0d", got, found); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    clear_counts();
    for (int i = 0; i < 600; i++) tick(1'b0, 6'h00, 8'h00, "after_reset");
    checks++; if (n_vs != 1) begin errors++; $display("FAIL after_reset_vsync_count got=%0d want=1", n_vs); end
    checks++; if (n_hs != 3) begin errors++; $display("FAIL after_reset_hsync_count got=%0d want=3", n_hs); end
    checks++; if (n_en != 0) begin errors++; $display("FAIL after_reset_lcd_en_count got=%0d want=0", n_en); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE4;
    xs = {6'h02, 2'($urandom)};
    bus.AB = 6'h00; bus.cpu_rnw = 1'b1; bus.lcd_cs = 1'b0; bus.data_in = 8'h00; bus.vram_data = 8'h00;
    model_reset();
    test_reset();
    test_disabled_frame();
    test_scan_frame();
    test_ce_freeze();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_fetch.md
# lcd_fetch

VRAM scan-out engine for the Supervision LCD path. It is the reader of the 8 KB video RAM that the DMA controller writes. It steals one VRAM slot every six `ce` ticks and presents the slot to the DMA controller as `lcd_en`; the DMA controller yields its own VRAM access during that slot. Each fetched byte is unpacked into four 2-bit pixels, and the block generates line and frame sync for the video output stage.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous reset, active-low.
- `ce` in 1: clock enable; all state advances only on `ce`, except reset.
- `AB` in 6: CPU register address, low bits.
- `cpu_rnw` in 1: CPU read/not-write.
- `lcd_cs` in 1: LCD register window select.
- `data_in` in 8: CPU write data.
- `vram_data` in 8: VRAM read data, valid in the `ce` tick after a slot.
- `vram_addr` out 13: VRAM read address.
- `lcd_en` out 1: slot-claim flag to the DMA controller. High only in the tick where `div==5` and a fetch occurs.
- `pixel` out 2: pixel value.
- `pix_valid` out 1: `pixel` valid this `ce` tick.
- `hsync` out 1: one-`ce` pulse at slot 0 of every line.
- `vsync` out 1: one-`ce` pulse at line 0, slot 0.

## Operation
**Registers.** CPU writes occur when `~cpu_rnw & lcd_cs & ce`.
- `AB=0x02`: `xscroll[7:0]`.
- `AB=0x03`: `yscroll[7:0]`.
- `AB=0x26`: bit 3 is `disp_en`. Other bits are ignored.
- Writes land in shadow registers. Shadows copy to the live registers at the `vsync` tick, so scroll and enable never change mid-frame.

**Counters.**
- `div` counts 0..5 and wraps.
- `slot` counts 0..47 and increments when `div==5`.
- `line` counts 0..163 and increments when `slot` wraps.
- Lines 0..159 are active; lines 160..163 are blank.

**Fetch.**
- Fetch slots are `slot` 0..39 of active lines with live `disp_en=1`.
- `vram_addr = line_base + xscroll[7:2] + slot`, truncated to 13 bits (wraps at 8 KB).
- `line_base` loads `yscroll*48` (mod 8192) at `vsync`. It then adds 48 (mod 8192) at each line wrap.

**Unpack.**
- On the `ce` tick with `div==0` following a fetch slot, `vram_data` loads into the shift register.
- Pixels are presented on ticks `div` 0,1,2,3 as bits [1:0], [3:2], [5:4], [7:6], with `pix_valid=1`. Lowest bits are the leftmost pixel.
- With no preceding fetch, `pix_valid=0` and `pixel=0`.

**Disabled display.**
- `lcd_en` stays 0 and no fetches occur.
- `pix_valid` still pulses over the active region with `pixel=0`, keeping raster geometry fixed.
- `hsync` and `vsync` always run.

## Timing
- Reset values: `div`, `slot`, `line`, `line_base`, `xscroll`, `yscroll`, `disp_en` and all shadows are 0. All outputs are 0.
- First `vsync` occurs on the first `ce` after reset release.
- Line length is 288 `ce`; frame length is 164 lines (47,232 `ce`).
- Fetch-to-first-pixel latency is 1 `ce`; the last pixel of a byte appears 4 `ce` after the slot.
- `vram_addr` is registered and stable for the entire slot tick.
- A CPU write coinciding with the `vsync` tick updates the shadow only; it takes effect at the next frame.
- Reset mid-line aborts the current fetch; the shift register is cleared.
- `ce` low freezes every counter and output.

## Configuration
- `LCD_FINE_SCROLL_EN` defined:
  - Fetch slots become 0..40 (41 bytes per line).
  - The first `xscroll[1:0]` pixels of each line have `pix_valid=0`.
  - Exactly 160 valid pixels are emitted per active line.
- `LCD_FINE_SCROLL_EN` undefined: `xscroll[1:0]` is ignored and 40 slots are fetched.

## Test plan
- Reset then `disp_en=1`, scrolls 0, VRAM[0]=0xE4 → line 0 pixels 0,1,2,3; `vram_addr` sequence 0,1,…,39; line 1 starts at 48.
- `yscroll=171` (171·48 = 8208) → `line_base=16` at `vsync`. A line with base 8160 wraps to address 0 at slot 32.
- `xscroll=0x08` → line 0 fetch addresses 2..41.
- DMA coexistence → `lcd_en` high exactly at `div==5` for slots 0..39 of lines 0..159, zero elsewhere; 6,400 assertions per frame.
- `AB=0x03` written mid-frame → addresses unchanged until the next `vsync`; a write on the `vsync` tick is deferred one frame.
- With `LCD_FINE_SCROLL_EN`, `xscroll=0x03` → first three pixels invalid, 160 valid pixels per line, 41 fetches per line.
